// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// Single clock domain with a cycle-count prescaler. A blanking gap sits
// between digits. New display values are taken over a valid/ready port
// into a one-deep pending slot and committed at frame boundaries.
module seg_scan_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 70,
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_MAX  = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int PCNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    localparam logic [PCNT_W-1:0] SHOW_LAST  = PCNT_W'(TICK_DIV - 1);
    localparam logic [PCNT_W-1:0] BLANK_LAST = PCNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [PCNT_W-1:0]              pcnt_q, pcnt_d;
    logic [NUM_DIGITS-1:0][3:0]     disp_nib_q, disp_nib_d;
    logic [NUM_DIGITS-1:0]          disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0][3:0]     pend_nib_q, pend_nib_d;
    logic [NUM_DIGITS-1:0]          pend_dp_q, pend_dp_d;
    logic                           pend_full_q, pend_full_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic                           frame_start_q, frame_start_d;

    // Active-low gfedcba segment pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The pending slot being empty is the only ready condition; reset gates it off.
    assign wr_ready = ~pend_full_q & ~rst;

    // Next-state logic: scan FSM, prescaler, commit at frame wrap, write capture,
    // and the output image derived from the *next* state so pins switch with it.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pcnt_d        = pcnt_q + PCNT_W'(1);
        disp_nib_d    = disp_nib_q;
        disp_dp_d     = disp_dp_q;
        pend_nib_d    = pend_nib_q;
        pend_dp_d     = pend_dp_q;
        pend_full_d   = pend_full_q;
        frame_start_d = 1'b0;
        an_d          = '1;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;

        case (state_q)
            ST_SHOW: begin
                if (pcnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    pcnt_d  = '0;
                end
            end
            default: begin
                if (pcnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    pcnt_d  = '0;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: digit 0 is next, commit any pending value.
                        idx_d         = '0;
                        frame_start_d = 1'b1;
                        if (pend_full_q) begin
                            disp_nib_d  = pend_nib_q;
                            disp_dp_d   = pend_dp_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase

        // Capture cannot collide with a commit: commit needs pend_full, capture needs it clear.
        if (wr_valid && wr_ready) begin
            pend_nib_d  = wr_data;
            pend_dp_d   = wr_dp;
            pend_full_d = 1'b1;
        end

        if (state_d == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_d != IDX_W'(i));
            end
            seg_d = hex_decode(disp_nib_d[idx_d]);
            dp_d  = ~disp_dp_d[idx_d];
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            idx_q         <= IDX_LAST;
            pcnt_q        <= '0;
            disp_nib_q    <= '0;
            disp_dp_q     <= '0;
            pend_nib_q    <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pcnt_q        <= pcnt_d;
            disp_nib_q    <= disp_nib_d;
            disp_dp_q     <= disp_dp_d;
            pend_nib_q    <= pend_nib_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a vector table for the first frames after reset,
// a free-running monitor with a queue of accepted writes as the display
// scoreboard, and hand sequences for held writes, frame timing and mid-run reset.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TICK  = 5;
    localparam int BLNK  = 2;
    localparam int FRAME = ND * (TICK + BLNK);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [15:0]   wr_data;
    logic [3:0]    wr_dp;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    seg_scan_ctrl #(
        .CLK_HZ(1000), .REFRESH_HZ(50), .NUM_DIGITS(ND), .BLANK_CYCLES(BLNK)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic [3:0]  wdp;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add(input int n, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input logic f, input logic r);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = '{1'b0, 16'h0, 4'h0, a, s, d, f, r};
            vecs.push_back(v);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [19:0] sb_q[$];
    logic [15:0] exp_nib;
    logic [3:0]  exp_dpv;
    logic        rst_e = 1'b1;
    logic        acc_prev;
    logic [19:0] acc_val;
    logic        prev_blank;
    logic        first_run;
    int          run, last_idx, last_fs;

    task automatic mon();
        logic cur_blank, exp_fs;
        int   lowidx;
        forever begin
            @(negedge clk);
            if (rst_e) begin
                chk("mon_reset_out", {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
                sb_q.delete();
                exp_nib = '0; exp_dpv = '0;
                acc_prev = 1'b0; prev_blank = 1'b1; first_run = 1'b1;
                run = 1; last_idx = ND - 1; last_fs = -1;
            end else begin
                if (frame_start && sb_q.size() > 0) {exp_nib, exp_dpv} = sb_q.pop_front();
                if (acc_prev) sb_q.push_back(acc_val);
                cur_blank = (an == 4'hF);
                lowidx = 0;
                for (int k = 0; k < ND; k++) if (!an[k]) lowidx = k;
                chk("mon_one_anode", ($countones(~an) <= 1), 1'b1);
                exp_fs = prev_blank && !cur_blank && (lowidx == 0);
                chk("mon_frame_start", frame_start, exp_fs);
                if (frame_start) begin
                    if (last_fs >= 0) chk("mon_fs_spacing", cyc - last_fs, FRAME);
                    last_fs = cyc;
                end
                if (cur_blank)
                    chk("mon_blank_out", {seg, dp}, {7'h7F, 1'b1});
                else
                    chk("mon_show_out", {seg, dp},
                        {HEX[exp_nib[4*lowidx +: 4]], ~exp_dpv[lowidx]});
                if (cur_blank == prev_blank) begin
                    run++;
                end else begin
                    if (!(first_run && prev_blank))
                        chk(prev_blank ? "mon_blank_len" : "mon_show_len", run,
                            prev_blank ? BLNK : TICK);
                    first_run = 1'b0;
                    if (!cur_blank) begin
                        chk("mon_digit_order", lowidx, (last_idx + 1) % ND);
                        last_idx = lowidx;
                    end
                    run = 1;
                end
                prev_blank = cur_blank;
            end
            acc_prev = wr_valid && wr_ready && !rst;
            acc_val  = {wr_data, wr_dp};
            rst_e    = rst;
        end
    endtask

    // ---------------- hand-sequence helpers ----------------
    task automatic wait_fs(output int w);
        bit got = 0;
        w = 0;
        while (!got && w < 200) begin
            @(negedge clk);
            if (frame_start) got = 1; else w++;
        end
        if (!got) begin
            errors++;
            $display("FAIL wait_fs: no frame_start within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p,
                         output int waited, output logic fs_at_acc);
        bit got = 0;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = d; wr_dp = p;
        waited = 0; fs_at_acc = 1'b0;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (wr_ready) begin
                got = 1; fs_at_acc = frame_start;
            end else waited++;
        end
        if (!got) begin
            errors++;
            $display("FAIL offer: write %0h not accepted within 100 cycles", d);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic check_frame(input logic [15:0] d, input logic [3:0] p,
                               input string nm, output int w);
        logic [3:0] seen = '0;
        wait_fs(w);
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                if (!seen[k] && an == ~(4'b0001 << k)) begin
                    seen[k] = 1'b1;
                    chk($sformatf("%s_digit%0d", nm, k), {seg, dp}, {HEX[d[4*k +: 4]], ~p[k]});
                end
            end
        end
        chk($sformatf("%s_all_digits_seen", nm), seen, 4'hF);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          w, w2;
        logic        af;
        bit          got;
        logic [15:0] vals [4];
        logic [3:0]  dps  [4];

        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
        fork mon(); join_none

        // First frames after reset; a write of 3A7F/0010 is offered in vector 4.
        add(2, 4'hF, 7'h7F, 1, 0, 1);
        add(1, 4'hE, 7'h40, 1, 1, 1);
        add(2, 4'hE, 7'h40, 1, 0, 1);
        add(2, 4'hE, 7'h40, 1, 0, 0);
        add(2, 4'hF, 7'h7F, 1, 0, 0);
        add(5, 4'hD, 7'h40, 1, 0, 0);
        add(2, 4'hF, 7'h7F, 1, 0, 0);
        add(5, 4'hB, 7'h40, 1, 0, 0);
        add(2, 4'hF, 7'h7F, 1, 0, 0);
        add(5, 4'h7, 7'h40, 1, 0, 0);
        add(2, 4'hF, 7'h7F, 1, 0, 0);
        add(1, 4'hE, 7'h0E, 1, 1, 1);
        add(4, 4'hE, 7'h0E, 1, 0, 1);
        add(2, 4'hF, 7'h7F, 1, 0, 1);
        add(1, 4'hD, 7'h78, 0, 0, 1);
        vecs[4].wv = 1'b1; vecs[4].wd = 16'h3A7F; vecs[4].wdp = 4'b0010;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {an, seg, dp, frame_start, wr_ready}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            wr_valid = vecs[i].wv; wr_data = vecs[i].wd; wr_dp = vecs[i].wdp;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {an, seg, dp, frame_start, wr_ready},
                {vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].fs, vecs[i].rdy});
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;

        // Held second write while the slot is full: accepted only at the commit cycle.
        offer(16'h5B2C, 4'b1000, w, af);
        chk("t3_first_immediate", w, 0);
        offer(16'hE0D9, 4'b0001, w, af);
        chk("t3_ready_at_commit", af, 1'b1);
        chk("t3_held_waited", (w > 0), 1'b1);
        check_frame(16'hE0D9, 4'b0001, "t3", w2);
        chk("t3_one_frame_later", w2, FRAME - 1);

        // Ten frames of free-running scan.
        wait_fs(w);
        w2 = cyc;
        repeat (10) wait_fs(w);
        chk("t4_ten_frames", cyc - w2, 10 * FRAME);

        // Reset during digit 2 SHOW with a write pending.
        wait_fs(w);
        offer(16'hFFFF, 4'hF, w, af);
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (an == 4'hB) got = 1;
        end
        chk("t5_reached_digit2", got, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_reset_out", {an, seg, dp, frame_start, wr_ready}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after_release", wr_ready, 1'b1);
        check_frame(16'h0000, 4'h0, "t5", w);
        chk("t5_first_frame_delay", w, BLNK - 1);

        // Sweep all sixteen nibbles and each decimal point.
        vals = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        dps  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int v = 0; v < 4; v++) begin
            wait_fs(w);
            offer(vals[v], dps[v], w, af);
            check_frame(vals[v], dps[v], $sformatf("t6_w%0d", v), w);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
